// File: rtl/pci_master_pkg.sv
// Shared types and constants for the PCI master burst controller.
// Covers the FSM states, the PCI bus command codes and the bit positions in the core status word.
package pci_master_pkg;

    typedef enum logic [2:0] {IDLE, REQ, XFER, RTY, DONE, DEAD} state_t;

    localparam logic [3:0] MEM_RD  = 4'b0110;
    localparam logic [3:0] MEM_WR  = 4'b0111;
    localparam logic [3:0] MEM_RDL = 4'b1110;

    localparam int CSR_MABORT = 39;
    localparam int CSR_TABORT = 38;
    localparam int CSR_RETRY  = 36;

endpackage

// File: rtl/pci_master_wr_hold.sv
// One-entry write holding register between the user write stream and the core data path.
// The entry is freed only by a completed data phase, so a retried phase re-presents the same word.
module pci_master_wr_hold (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        load_en,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        consume,
    output logic [31:0] hold_data,
    output logic        hold_full
);

    logic        full_reg;
    logic [31:0] data_reg;
    logic        take;

    assign take      = consume & full_reg;
    assign in_ready  = load_en & (~full_reg | take);
    assign hold_data = data_reg;
    assign hold_full = full_reg;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (in_valid && in_ready) begin
            full_reg <= 1'b1;
            data_reg <= in_data;
        end else if (take) begin
            full_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/pci_master_burst_ctl.sv
// User-side PCI initiator: runs read/write bursts through the core's master port,
// resuming after retry/disconnect at the next undone dword and locking out on fatal aborts.
module pci_master_burst_ctl
    import pci_master_pkg::*;
#(
    parameter  int MAX_LEN   = 16,
    parameter  int RETRY_MAX = 8,
    parameter  int USE_MRL   = 1,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             cmd_done,
    output logic             cmd_err,
    input  logic             cmd_abort,
    input  logic [31:0]      adio_out,
    output logic [31:0]      adio_in,
    input  logic             m_data,
    input  logic             m_data_vld,
    input  logic             m_addr_n,
    input  logic [39:0]      csr,
    output logic             request,
    output logic             requesthold,
    output logic             complete,
    output logic             m_ready,
    output logic [3:0]       m_cbe,
    output logic             m_wrdn
);

    localparam int RTY_W = $clog2(RETRY_MAX + 1);

    state_t             state_reg, state_next;
    logic               dir_reg, dir_next;
    logic [31:0]        base_reg, base_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   done_cnt_reg, done_next;
    logic [RTY_W-1:0]   rty_cnt_reg, rty_next;
    logic               err_reg, err_next;
    logic               m_data_reg, fatal_reg, retry_reg;
    logic               complete_reg, complete_next;
    logic               cmd_done_reg, cmd_err_reg, done_pulse;
    logic               rd_valid_reg;
    logic [31:0]        rd_data_reg;
    logic [LEN_W-1:0]   remaining, rem_after;
    logic [31:0]        cur_addr, hold_data;
    logic               hold_full, in_xfer, addr_phase, m_data_fell, rd_strobe;
    logic               unused_in;

    assign in_xfer     = (state_reg == XFER);
    assign m_data_fell = m_data_reg & ~m_data;
    assign remaining   = len_reg - done_cnt_reg;
    assign cur_addr    = base_reg + (32'(done_cnt_reg) << 2);
    assign addr_phase  = in_xfer & ~m_addr_n;
    assign rd_strobe   = in_xfer & ~dir_reg & m_data_vld;
    assign unused_in   = ^{csr[37], csr[35:0], cmd_addr[1:0]};

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        base_next  = base_reg;
        len_next   = len_reg;
        done_next  = done_cnt_reg;
        rty_next   = rty_cnt_reg;
        err_next   = err_reg;
        // Strobes beyond the command length are ignored rather than wrapping the count.
        if (in_xfer && m_data_vld && (done_cnt_reg < len_reg))
            done_next = done_cnt_reg + 1'b1;
        rem_after = len_reg - done_next;
        case (state_reg)
            IDLE: if (cmd_valid) begin
                dir_next  = cmd_dir;
                base_next = {cmd_addr[31:2], 2'b00};
                if (cmd_len == '0)
                    len_next = LEN_W'(1);
                else if (cmd_len > LEN_W'(MAX_LEN))
                    len_next = LEN_W'(MAX_LEN);
                else
                    len_next = cmd_len;
                done_next  = '0;
                rty_next   = '0;
                err_next   = 1'b0;
                state_next = REQ;
            end
            REQ:  state_next = XFER;
            XFER: if (m_data_fell) begin
                if (fatal_reg) begin
                    err_next   = 1'b1;
                    state_next = DEAD;
                end else if (rem_after == '0) begin
                    err_next   = 1'b0;
                    state_next = DONE;
                end else if (retry_reg || (rem_after != '0)) begin
                    state_next = RTY;
                end
            end
            RTY: begin
                if (rty_cnt_reg + 1'b1 == RTY_W'(RETRY_MAX)) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    rty_next   = rty_cnt_reg + 1'b1;
                    state_next = REQ;
                end
            end
            DONE: state_next = IDLE;
            DEAD: if (cmd_abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        complete_next = ((state_next == REQ) || (state_next == XFER)) &&
                        ((len_next - done_next) <= LEN_W'(1));
        done_pulse    = (state_next == DONE) || ((state_next == DEAD) && (state_reg != DEAD));
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            dir_reg      <= 1'b0;
            base_reg     <= '0;
            len_reg      <= '0;
            done_cnt_reg <= '0;
            rty_cnt_reg  <= '0;
            err_reg      <= 1'b0;
            complete_reg <= 1'b0;
            cmd_done_reg <= 1'b0;
            cmd_err_reg  <= 1'b0;
            m_data_reg   <= 1'b0;
            fatal_reg    <= 1'b0;
            retry_reg    <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            base_reg     <= base_next;
            len_reg      <= len_next;
            done_cnt_reg <= done_next;
            rty_cnt_reg  <= rty_next;
            err_reg      <= err_next;
            complete_reg <= complete_next;
            cmd_done_reg <= done_pulse;
            cmd_err_reg  <= done_pulse & err_next;
            m_data_reg   <= m_data;
            // Termination flags live for one attempt: wiped by the address phase, sticky in data.
            if (!m_addr_n) begin
                fatal_reg <= 1'b0;
                retry_reg <= 1'b0;
            end else if (m_data) begin
                fatal_reg <= fatal_reg | csr[CSR_MABORT] | csr[CSR_TABORT];
                retry_reg <= retry_reg | csr[CSR_RETRY];
            end
            rd_valid_reg <= rd_strobe;
            if (rd_strobe)
                rd_data_reg <= adio_out;
        end
    end

    // Never pull a dword from the user stream beyond the command length.
    pci_master_wr_hold u_wr_hold (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .load_en   (in_xfer & dir_reg & (done_next < len_reg)),
        .in_data   (wr_data),
        .in_valid  (wr_valid),
        .in_ready  (wr_ready),
        .consume   (in_xfer & dir_reg & m_data_vld),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    assign cmd_ready   = (state_reg == IDLE);
    assign request     = (state_reg == REQ);
    assign requesthold = 1'b0;
    assign complete    = complete_reg;
    assign cmd_done    = cmd_done_reg;
    assign cmd_err     = cmd_err_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;
    assign m_wrdn      = dir_reg;
    assign m_ready     = in_xfer & (dir_reg ? hold_full : 1'b1);
    assign m_cbe       = !addr_phase ? 4'b0000 :
                         dir_reg     ? MEM_WR :
                         ((USE_MRL != 0) && (remaining > LEN_W'(1))) ? MEM_RDL : MEM_RD;
    assign adio_in     = addr_phase                 ? cur_addr  :
                         (in_xfer & m_data & dir_reg) ? hold_data : {32{1'bz}};

endmodule

// File: tb/tb_pci_master_burst_ctl.sv
// Directed bench for pci_master_burst_ctl with a small behavioural PCI core model.
// Each check prints one line only on mismatch; a summary line ends the run.
module tb_pci_master_burst_ctl;

    localparam int LEN_W = 5;

    logic             CLK = 1'b0;
    logic             reset_n;
    logic             cmd_valid, cmd_ready, cmd_dir;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [31:0]      wr_data;
    logic             wr_valid, wr_ready;
    logic [31:0]      rd_data;
    logic             rd_valid, cmd_done, cmd_err, cmd_abort;
    logic [31:0]      adio_out, adio_in;
    logic             m_data, m_data_vld, m_addr_n, trdy;
    logic [39:0]      csr;
    logic             request, requesthold, complete, m_ready, m_wrdn;
    logic [3:0]       m_cbe;

    int tests = 0;
    int fails = 0;
    int req_total = 0;
    int done_total = 0;
    int wait_total = 0;
    logic [31:0] wq[$];
    logic [31:0] rq[$];

    always #5 CLK = ~CLK;

    assign m_data_vld = m_data & trdy & m_ready;

    pci_master_burst_ctl #(.MAX_LEN(16), .RETRY_MAX(2), .USE_MRL(1)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_abort(cmd_abort),
        .adio_out(adio_out), .adio_in(adio_in),
        .m_data(m_data), .m_data_vld(m_data_vld), .m_addr_n(m_addr_n), .csr(csr),
        .request(request), .requesthold(requesthold), .complete(complete),
        .m_ready(m_ready), .m_cbe(m_cbe), .m_wrdn(m_wrdn)
    );

    always @(negedge CLK) begin
        if (request) req_total++;
        if (cmd_done) done_total++;
        if (m_data && !m_ready) wait_total++;
        if (m_data_vld && m_wrdn) wq.push_back(adio_in);
        if (rd_valid) rq.push_back(rd_data);
    end

    function automatic logic [31:0] wd(input int i);
        return 32'hD0D0_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] rw(input int i);
        return 32'hA000_0001 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue_cmd(input logic dir, input logic [31:0] addr, input logic [LEN_W-1:0] len);
        logic seen;
        seen = 1'b0;
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (cmd_ready) seen = 1'b1;
        end
        check("cmd_accept", 32'(seen), 32'd1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(output logic seen, output logic creq);
        seen = 1'b0;
        creq = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (request) begin
                seen = 1'b1;
                creq = complete;
            end
        end
    endtask

    // term: 0 normal end, 1 retry/disconnect, 2 target abort
    task automatic core_attempt(input int n, input int term, output logic [31:0] addr,
                                output logic [3:0] cbe, output logic [15:0] cmask,
                                output logic creq);
        int xfers, budget, bi;
        logic seen;
        addr = '0; cbe = '0; cmask = '0;
        wait_req(seen, creq);
        check("req_seen", 32'(seen), 32'd1);
        if (seen) begin
            @(posedge CLK); #1;
            m_addr_n = 1'b0;
            @(negedge CLK);
            addr = adio_in;
            cbe  = m_cbe;
            @(posedge CLK); #1;
            m_addr_n = 1'b1; m_data = 1'b1; trdy = (n > 0); adio_out = rw(0);
            xfers = 0; budget = 100;
            while (xfers < n && budget > 0) begin
                @(negedge CLK);
                if (m_data_vld) begin
                    cmask[xfers] = complete;
                    xfers++;
                end
                budget--;
                @(posedge CLK); #1;
                adio_out = rw(xfers);
            end
            check("xfer_count", 32'(xfers), 32'(n));
            trdy = 1'b0;
            if (term != 0) begin
                bi = (term == 1) ? 36 : 38;
                csr[bi] = 1'b1;
                @(posedge CLK); #1;
                csr = '0;
            end
            m_data = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        logic seen, err;
        seen = 1'b0; err = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (cmd_done) begin
                seen = 1'b1;
                err  = cmd_err;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic feed(input int n, input int gap_at);
        int idx, gap, budget;
        idx = 0; gap = 0; budget = 300;
        while (idx < n && budget > 0) begin
            @(posedge CLK); #1;
            if (gap > 0) begin
                wr_valid = 1'b0;
                gap--;
            end else begin
                wr_valid = 1'b1;
                wr_data  = wd(idx);
            end
            @(negedge CLK);
            if (wr_valid && wr_ready) begin
                idx++;
                if (idx == gap_at) gap = 2;
            end
            budget--;
        end
        @(posedge CLK); #1;
        wr_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_request"}, 32'(request), 32'd0);
        check({tag, "_reqhold"}, 32'(requesthold), 32'd0);
        check({tag, "_complete"}, 32'(complete), 32'd0);
        check({tag, "_m_ready"}, 32'(m_ready), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_cmd_done"}, 32'(cmd_done), 32'd0);
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  c;
        logic [15:0] cm;
        logic        cr, seen;
        int          wb, rb, rt, wt, dt;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; cmd_abort = 1'b0; adio_out = '0;
        m_data = 1'b0; m_addr_n = 1'b1; trdy = 1'b0; csr = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK); #1;
        reset_n = 1'b1;

        // Read len=4 @0x1000, back-to-back data phases
        rb = rq.size();
        issue_cmd(1'b0, 32'h0000_1000, 5'd4);
        core_attempt(4, 0, a, c, cm, cr);
        check("rd4_addr", a, 32'h0000_1000);
        check("rd4_cbe", 32'(c), 32'hE);
        check("rd4_req_complete", 32'(cr), 32'd0);
        check("rd4_complete_mask", 32'(cm), 32'h8);
        wait_done("rd4", 1'b0);
        check("rd4_count", 32'(rq.size() - rb), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd4_data%0d", i), (rb + i < rq.size()) ? rq[rb + i] : 32'hX, rw(i));

        // Write len=3 with a two-cycle stall in the user stream
        wb = wq.size(); wt = wait_total;
        issue_cmd(1'b1, 32'h0000_5000, 5'd3);
        fork
            feed(3, 2);
            core_attempt(3, 0, a, c, cm, cr);
        join
        check("wr3_addr", a, 32'h0000_5000);
        check("wr3_cbe", 32'(c), 32'h7);
        check("wr3_complete_mask", 32'(cm), 32'h4);
        check("wr3_wait_cycles", 32'(wait_total - wt), 32'd2);
        wait_done("wr3", 1'b0);
        check("wr3_count", 32'(wq.size() - wb), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("wr3_data%0d", i), (wb + i < wq.size()) ? wq[wb + i] : 32'hX, wd(i));

        // Write len=8 @0x2000, retry after 3 dwords, resume at 0x200C
        wb = wq.size(); rt = req_total;
        issue_cmd(1'b1, 32'h0000_2000, 5'd8);
        fork
            feed(8, 0);
            begin
                core_attempt(3, 1, a, c, cm, cr);
                check("wr8_addr0", a, 32'h0000_2000);
                check("wr8_mask0", 32'(cm), 32'h0);
                core_attempt(5, 0, a, c, cm, cr);
                check("wr8_addr1", a, 32'h0000_200C);
                check("wr8_cbe1", 32'(c), 32'h7);
                check("wr8_req_complete1", 32'(cr), 32'd0);
                check("wr8_mask1", 32'(cm), 32'h10);
            end
        join
        wait_done("wr8", 1'b0);
        check("wr8_requests", 32'(req_total - rt), 32'd2);
        check("wr8_count", 32'(wq.size() - wb), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("wr8_data%0d", i), (wb + i < wq.size()) ? wq[wb + i] : 32'hX, wd(i));

        // Retry limit (RETRY_MAX=2): zero-data retry on every attempt
        rt = req_total;
        issue_cmd(1'b0, 32'h0000_6000, 5'd2);
        core_attempt(0, 1, a, c, cm, cr);
        check("rtylim_addr0", a, 32'h0000_6000);
        check("rtylim_cbe0", 32'(c), 32'hE);
        core_attempt(0, 1, a, c, cm, cr);
        check("rtylim_addr1", a, 32'h0000_6000);
        wait_done("rtylim", 1'b1);
        repeat (5) @(negedge CLK);
        check("rtylim_requests", 32'(req_total - rt), 32'd2);

        // Target abort during a read: lockout until cmd_abort
        issue_cmd(1'b0, 32'h0000_3000, 5'd2);
        core_attempt(1, 2, a, c, cm, cr);
        wait_done("fatal", 1'b1);
        rt = req_total;
        repeat (20) @(negedge CLK);
        check("dead_requests", 32'(req_total - rt), 32'd0);
        check("dead_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge CLK); #1;
        cmd_abort = 1'b1;
        @(posedge CLK); #1;
        cmd_abort = 1'b0;
        @(negedge CLK);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset in the middle of a write burst
        dt = done_total;
        issue_cmd(1'b1, 32'h0000_7000, 5'd4);
        wr_data = 32'h7777_0000; wr_valid = 1'b1;
        wait_req(seen, cr);
        check("rst_req_seen", 32'(seen), 32'd1);
        @(posedge CLK); #1;
        m_addr_n = 1'b0;
        @(posedge CLK); #1;
        m_addr_n = 1'b1; m_data = 1'b1; trdy = 1'b1;
        @(negedge CLK);
        check("pre_rst_m_ready", 32'(m_ready), 32'd1);
        @(posedge CLK); #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_data = 1'b0; trdy = 1'b0; wr_valid = 1'b0;
        @(posedge CLK); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_no_done", 32'(done_total - dt), 32'd0);

        // New command after reset: len=0 treated as 1, unaligned address forced aligned
        rb = rq.size();
        issue_cmd(1'b0, 32'h0000_4002, 5'd0);
        core_attempt(1, 0, a, c, cm, cr);
        check("rd1_addr", a, 32'h0000_4000);
        check("rd1_cbe", 32'(c), 32'h6);
        check("rd1_req_complete", 32'(cr), 32'd1);
        check("rd1_complete_mask", 32'(cm), 32'h1);
        wait_done("rd1", 1'b0);
        check("rd1_count", 32'(rq.size() - rb), 32'd1);
        check("rd1_data", (rb < rq.size()) ? rq[rb] : 32'hX, rw(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
